// File: rtl/urv_dm_arbiter_pkg.sv
// Shared types for the urv data-memory arbiter: FSM states, owner codes and the latched transfer.
package urv_dm_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StBusyCore = 2'd1,
      StBusyAux  = 2'd2
   } arb_state_e;

   localparam logic OwnerCore = 1'b0;
   localparam logic OwnerAux  = 1'b1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic        load;
      logic        store;
   } xfer_t;

   // A requester presenting load and store together gets a store.
   function automatic xfer_t make_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [3:0] sel, input logic load,
                                       input logic store);
      xfer_t x;
      x.addr  = addr;
      x.wdata = wdata;
      x.sel   = sel;
      x.load  = load & ~store;
      x.store = store;
      return x;
   endfunction

endpackage

// File: rtl/urv_dm_arbiter_if.sv
// Bundle of core, aux and memory-side signals around the data-memory arbiter.
interface urv_dm_arbiter_if;

   logic [31:0] c_addr_i;
   logic [31:0] c_wdata_i;
   logic [3:0]  c_sel_i;
   logic        c_load_i;
   logic        c_store_i;
   logic        c_ack_o;
   logic [31:0] c_rdata_o;
   logic        c_err_o;

   logic [31:0] a_addr_i;
   logic [31:0] a_wdata_i;
   logic [3:0]  a_sel_i;
   logic        a_load_i;
   logic        a_store_i;
   logic        a_ack_o;
   logic [31:0] a_rdata_o;
   logic        a_err_o;

   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [3:0]  m_sel_o;
   logic        m_load_o;
   logic        m_store_o;
   logic        m_ack_i;
   logic [31:0] m_rdata_i;

   logic        owner_o;
   logic        busy_o;

   modport slave (
      input  c_addr_i, c_wdata_i, c_sel_i, c_load_i, c_store_i,
      input  a_addr_i, a_wdata_i, a_sel_i, a_load_i, a_store_i,
      input  m_ack_i, m_rdata_i,
      output c_ack_o, c_rdata_o, c_err_o,
      output a_ack_o, a_rdata_o, a_err_o,
      output m_addr_o, m_wdata_o, m_sel_o, m_load_o, m_store_o,
      output owner_o, busy_o
   );

   modport master (
      output c_addr_i, c_wdata_i, c_sel_i, c_load_i, c_store_i,
      output a_addr_i, a_wdata_i, a_sel_i, a_load_i, a_store_i,
      output m_ack_i, m_rdata_i,
      input  c_ack_o, c_rdata_o, c_err_o,
      input  a_ack_o, a_rdata_o, a_err_o,
      input  m_addr_o, m_wdata_o, m_sel_o, m_load_o, m_store_o,
      input  owner_o, busy_o
   );

endinterface

// File: rtl/urv_dm_arbiter.sv
// Core-priority arbiter sharing one single-beat data-memory port with an aux master.
// Define URV_DM_ARB_TIMEOUT_EN to complete stalled transfers with an error after TIMEOUT_CYCLES.
module urv_dm_arbiter
   import urv_dm_arbiter_pkg::*;
#(
   parameter int unsigned AUX_MAX_WAIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic             clk_i,
   input logic             rst_n_i,
   urv_dm_arbiter_if.slave bus
);

   localparam logic [3:0] WaitMax = 4'(AUX_MAX_WAIT);

   arb_state_e  state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        owner_q, owner_d;
   logic        busy_q, busy_d;
   xfer_t       xfer_q, xfer_d;
   logic        c_ack_q, c_ack_d, a_ack_q, a_ack_d;
   logic [31:0] c_rdata_q, c_rdata_d, a_rdata_q, a_rdata_d;

   logic c_req, a_req, ack_pending, grant_aux, grant_core, done;

   assign c_req       = bus.c_load_i | bus.c_store_i;
   assign a_req       = bus.a_load_i | bus.a_store_i;
   // Requesters still hold their request during the ack cycle, so no grant is made then.
   assign ack_pending = c_ack_q | a_ack_q;
   assign grant_aux   = (state_q == StIdle) && !ack_pending && a_req &&
                        (!c_req || (wait_q == WaitMax));
   assign grant_core  = (state_q == StIdle) && !ack_pending && c_req && !grant_aux;

`ifdef URV_DM_ARB_TIMEOUT_EN
   localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       c_err_q, c_err_d, a_err_q, a_err_d;
   logic       tmo_hit;

   assign tmo_hit = (tmo_cnt_q == TmoLast);
   assign done    = bus.m_ack_i | tmo_hit;
`else
   assign done    = bus.m_ack_i;
`endif

   always_comb begin
      state_d   = state_q;
      wait_d    = a_req ? wait_q : 4'd0;
      owner_d   = owner_q;
      busy_d    = busy_q;
      xfer_d    = xfer_q;
      c_ack_d   = 1'b0;
      a_ack_d   = 1'b0;
      c_rdata_d = c_rdata_q;
      a_rdata_d = a_rdata_q;
`ifdef URV_DM_ARB_TIMEOUT_EN
      c_err_d   = 1'b0;
      a_err_d   = 1'b0;
      tmo_cnt_d = tmo_cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (grant_aux) begin
               state_d = StBusyAux;
               owner_d = OwnerAux;
               busy_d  = 1'b1;
               wait_d  = 4'd0;
               xfer_d  = make_xfer(bus.a_addr_i, bus.a_wdata_i, bus.a_sel_i, bus.a_load_i,
                                   bus.a_store_i);
`ifdef URV_DM_ARB_TIMEOUT_EN
               tmo_cnt_d = 8'd0;
`endif
            end else if (grant_core) begin
               state_d = StBusyCore;
               owner_d = OwnerCore;
               busy_d  = 1'b1;
               if (a_req && (wait_q < WaitMax)) wait_d = wait_q + 4'd1;
               xfer_d  = make_xfer(bus.c_addr_i, bus.c_wdata_i, bus.c_sel_i, bus.c_load_i,
                                   bus.c_store_i);
`ifdef URV_DM_ARB_TIMEOUT_EN
               tmo_cnt_d = 8'd0;
`endif
            end
         end
         StBusyCore, StBusyAux: begin
            if (done) begin
               state_d      = StIdle;
               busy_d       = 1'b0;
               xfer_d.load  = 1'b0;
               xfer_d.store = 1'b0;
               if (state_q == StBusyCore) begin
                  c_ack_d = 1'b1;
                  if (bus.m_ack_i) begin
                     if (xfer_q.load) c_rdata_d = bus.m_rdata_i;
                  end
`ifdef URV_DM_ARB_TIMEOUT_EN
                  else begin
                     c_err_d   = 1'b1;
                     c_rdata_d = 32'd0;
                  end
`endif
               end else begin
                  a_ack_d = 1'b1;
                  if (bus.m_ack_i) begin
                     if (xfer_q.load) a_rdata_d = bus.m_rdata_i;
                  end
`ifdef URV_DM_ARB_TIMEOUT_EN
                  else begin
                     a_err_d   = 1'b1;
                     a_rdata_d = 32'd0;
                  end
`endif
               end
            end
`ifdef URV_DM_ARB_TIMEOUT_EN
            else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d      = StIdle;
            busy_d       = 1'b0;
            xfer_d.load  = 1'b0;
            xfer_d.store = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         wait_q    <= 4'd0;
         owner_q   <= OwnerCore;
         busy_q    <= 1'b0;
         xfer_q    <= '0;
         c_ack_q   <= 1'b0;
         a_ack_q   <= 1'b0;
         c_rdata_q <= 32'd0;
         a_rdata_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         xfer_q    <= xfer_d;
         c_ack_q   <= c_ack_d;
         a_ack_q   <= a_ack_d;
         c_rdata_q <= c_rdata_d;
         a_rdata_q <= a_rdata_d;
      end
   end

`ifdef URV_DM_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt_q <= 8'd0;
         c_err_q   <= 1'b0;
         a_err_q   <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         c_err_q   <= c_err_d;
         a_err_q   <= a_err_d;
      end
   end

   assign bus.c_err_o = c_err_q;
   assign bus.a_err_o = a_err_q;
`else
   assign bus.c_err_o = 1'b0;
   assign bus.a_err_o = 1'b0;
`endif

   assign bus.c_ack_o   = c_ack_q;
   assign bus.c_rdata_o = c_rdata_q;
   assign bus.a_ack_o   = a_ack_q;
   assign bus.a_rdata_o = a_rdata_q;
   assign bus.m_addr_o  = xfer_q.addr;
   assign bus.m_wdata_o = xfer_q.wdata;
   assign bus.m_sel_o   = xfer_q.sel;
   assign bus.m_load_o  = xfer_q.load;
   assign bus.m_store_o = xfer_q.store;
   assign bus.owner_o   = owner_q;
   assign bus.busy_o    = busy_q;

endmodule
